// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg: store-size codes, MMIO offsets and MMIO tag default. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [7:0] OFF_CNT_LO = 8'h00;
  localparam logic [7:0] OFF_CNT_HI = 8'h04;
  localparam logic [7:0] OFF_GPIO   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CMP_LO = 8'h10;
  localparam logic [7:0] OFF_CMP_HI = 8'h14;

  localparam logic [3:0] MMIO_TAG_DEFAULT = 4'hF;

endpackage

`default_nettype wire

// File: rtl/dmem_mmio_regs.sv
// -----------------------------------------------------------------------------
// dmem_mmio_regs: 64-bit cycle counter, GPIO, sticky status, optional timer
// compare (macro DMEM_TIMER_IRQ_EN). Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_mmio_regs
  import riscv_pkg::*;
(
  input  logic        iclk,
  input  logic        irstn,
  input  logic        iwe,
  input  logic [7:0]  ioffset,
  input  logic [31:0] iwdata,
  input  logic        istore_err,
  output logic [31:0] ordata,
  output logic [31:0] ogpio,
  output logic        oerr,
  output logic        otimer_irq
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] gpio_q, gpio_d;
  logic        status_q, status_d;

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      cnt_q    <= 64'd0;
      gpio_q   <= 32'd0;
      status_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      gpio_q   <= gpio_d;
      status_q <= status_d;
    end
  end

  // A write to one counter half freezes the other half for that cycle.
  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    gpio_d   = gpio_q;
    status_d = status_q;
    if (iwe) begin
      case (ioffset)
        OFF_CNT_LO: cnt_d = {cnt_q[63:32], iwdata};
        OFF_CNT_HI: cnt_d = {iwdata, cnt_q[31:0]};
        OFF_GPIO:   gpio_d = iwdata;
        OFF_STATUS: status_d = status_q & ~iwdata[0];
        default:    ;
      endcase
    end
    if (istore_err) status_d = 1'b1;
  end

`ifdef DMEM_TIMER_IRQ_EN
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      cmp_q <= '1;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q;
    if (cnt_q == cmp_q) irq_d = 1'b1;
    if (iwe && ioffset == OFF_CMP_LO) begin
      cmp_d = {cmp_q[63:32], iwdata};
      irq_d = 1'b0;
    end
    if (iwe && ioffset == OFF_CMP_HI) begin
      cmp_d = {iwdata, cmp_q[31:0]};
      irq_d = 1'b0;
    end
  end

  assign otimer_irq = irq_q;
`else
  assign otimer_irq = 1'b0;
`endif

  always_comb begin
    ordata = 32'd0;
    case (ioffset)
      OFF_CNT_LO: ordata = cnt_q[31:0];
      OFF_CNT_HI: ordata = cnt_q[63:32];
      OFF_GPIO:   ordata = gpio_q;
      OFF_STATUS: ordata = {31'd0, status_q};
`ifdef DMEM_TIMER_IRQ_EN
      OFF_CMP_LO: ordata = cmp_q[31:0];
      OFF_CMP_HI: ordata = cmp_q[63:32];
`endif
      default:    ordata = 32'd0;
    endcase
  end

  assign ogpio = gpio_q;
  assign oerr  = status_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder: data-side RAM + MMIO responder for the core memory stage.
// Optional feature macro: DMEM_TIMER_IRQ_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import riscv_pkg::*;
#(
  parameter int         MP_DATA_WIDTH = 32,
  parameter int         MP_RAM_AW     = 10,
  parameter logic [3:0] MP_MMIO_TAG   = MMIO_TAG_DEFAULT
) (
  input  logic                     iclk,
  input  logic                     irstn,
  input  logic                     iwe_m,
  input  logic [1:0]               isize_m,
  input  logic [31:0]              iaddr_m,
  input  logic [MP_DATA_WIDTH-1:0] iwdata_m,
  output logic [MP_DATA_WIDTH-1:0] ordata_m,
  output logic [MP_DATA_WIDTH-1:0] ogpio,
  output logic                     oerr,
  output logic                     otimer_irq
);

  localparam int RAM_DEPTH = 2 ** MP_RAM_AW;

  logic                 mmio_sel;
  logic                 misalign;
  logic                 store_err;
  logic                 ram_we;
  logic                 mmio_we;
  logic [3:0]           lane_en;
  logic [31:0]          wdata_rep;
  logic [31:0]          ram_rdata;
  logic [31:0]          mmio_rdata;
  logic [MP_RAM_AW-1:0] ram_idx;
  logic                 unused_addr_bits;

  assign mmio_sel         = (iaddr_m[31:28] == MP_MMIO_TAG);
  assign ram_idx          = iaddr_m[MP_RAM_AW+1:2];
  assign unused_addr_bits = ^iaddr_m;

  always_comb begin
    lane_en   = 4'b0000;
    wdata_rep = iwdata_m;
    misalign  = 1'b1;
    case (isize_m)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << iaddr_m[1:0];
        wdata_rep = {4{iwdata_m[7:0]}};
        misalign  = 1'b0;
      end
      SZ_HALF: begin
        lane_en   = iaddr_m[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{iwdata_m[15:0]}};
        misalign  = iaddr_m[0];
      end
      SZ_WORD: begin
        lane_en   = 4'b1111;
        misalign  = |iaddr_m[1:0];
      end
      default: ;
    endcase
  end

  // MMIO is word-only; any sub-word MMIO store is flagged like a misalignment.
  assign store_err = iwe_m & (misalign | (mmio_sel & (isize_m != SZ_WORD)));
  assign ram_we    = iwe_m & ~store_err & ~mmio_sel & irstn;
  assign mmio_we   = iwe_m & ~store_err & mmio_sel;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [RAM_DEPTH];

    always_ff @(posedge iclk) begin
      if (ram_we && lane_en[g]) mem[ram_idx] <= wdata_rep[8*g +: 8];
    end

    assign ram_rdata[8*g +: 8] = mem[ram_idx];
  end

  dmem_mmio_regs u_mmio (
    .iclk       (iclk),
    .irstn      (irstn),
    .iwe        (mmio_we),
    .ioffset    (iaddr_m[7:0]),
    .iwdata     (iwdata_m),
    .istore_err (store_err),
    .ordata     (mmio_rdata),
    .ogpio      (ogpio),
    .oerr       (oerr),
    .otimer_irq (otimer_irq)
  );

  assign ordata_m = mmio_sel ? mmio_rdata : ram_rdata;

endmodule

`default_nettype wire
